// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-port backing memory between the CPU instruction-fetch
// port (read-only) and the data-memory port (read/write). At most one memory
// transaction is outstanding. When both ports request in the same IDLE cycle,
// the port that was not granted last wins (round-robin). A granted
// transaction that is never acknowledged is abandoned after TIMEOUT busy
// cycles. The abandoned transaction completes with zero data and sets a
// sticky error flag.
//
// Ports:
//   clk_i, rst_i             clock (rising edge), asynchronous active-high reset
//   if_req_i / if_addr_i     fetch request (level) and address
//   if_data_o / if_valid_o   fetched word and one-cycle completion pulse
//   dm_req_i / dm_we_i       data request (level) and write enable
//   dm_addr_i / dm_wdata_i   data address and write data
//   dm_rdata_o / dm_valid_o  read data and one-cycle completion pulse
//   mem_req_o / mem_we_o     backing-memory request and write enable
//   mem_addr_o / mem_wdata_o backing-memory address and write data
//   mem_ack_i / mem_rdata_i  backing-memory completion and read data
//   stall_o                  pipeline freeze while any request is unserved
//   err_o                    sticky timeout flag
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_valid_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } state_t;

  // 16 bits covers the whole legal TIMEOUT range (2..65535).
  localparam int              CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state_reg, state_next;
  // 1 = the data port received the most recent grant.
  logic                last_data_reg, last_data_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                we_reg, we_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   if_data_reg, if_data_next;
  logic [DATA_W-1:0]   dm_rdata_reg, dm_rdata_next;
  logic                err_reg, err_next;

  logic                grant_if;
  logic                grant_dm;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      last_data_reg <= 1'b1;  // first tie goes to fetch
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      cnt_reg       <= '0;
      if_data_reg   <= '0;
      dm_rdata_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      last_data_reg <= last_data_next;
      addr_reg      <= addr_next;
      we_reg        <= we_next;
      wdata_reg     <= wdata_next;
      cnt_reg       <= cnt_next;
      if_data_reg   <= if_data_next;
      dm_rdata_reg  <= dm_rdata_next;
      err_reg       <= err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state_reg == IDLE) begin
      if (if_req_i && dm_req_i) begin
        grant_if = last_data_reg;
        grant_dm = ~last_data_reg;
      end else begin
        grant_if = if_req_i;
        grant_dm = dm_req_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    last_data_next = last_data_reg;
    addr_next      = addr_reg;
    we_next        = we_reg;
    wdata_next     = wdata_reg;
    cnt_next       = cnt_reg;
    if_data_next   = if_data_reg;
    dm_rdata_next  = dm_rdata_reg;
    err_next       = err_reg;

    case (state_reg)
      IDLE: begin
        // The requester fields are sampled only here. They stay frozen on
        // mem_*_o for the whole transaction, whatever the CPU does next.
        if (grant_if) begin
          state_next     = BUSY_I;
          last_data_next = 1'b0;
          addr_next      = if_addr_i;
          we_next        = 1'b0;
          wdata_next     = '0;
          cnt_next       = '0;
        end else if (grant_dm) begin
          state_next     = BUSY_D;
          last_data_next = 1'b1;
          addr_next      = dm_addr_i;
          we_next        = dm_we_i;
          wdata_next     = dm_wdata_i;
          cnt_next       = '0;
        end
      end

      BUSY_I: begin
        if (mem_ack_i) begin
          if_data_next = mem_rdata_i;
          cnt_next     = '0;
          state_next   = RESP_I;
        end else if (cnt_reg == CNT_LAST) begin
          // TIMEOUT busy cycles without an ack: give up with zero data.
          if_data_next = '0;
          err_next     = 1'b1;
          cnt_next     = '0;
          state_next   = RESP_I;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      BUSY_D: begin
        if (mem_ack_i) begin
          // A write returns no data, so the last read value stays visible.
          if (!we_reg) begin
            dm_rdata_next = mem_rdata_i;
          end
          cnt_next   = '0;
          state_next = RESP_D;
        end else if (cnt_reg == CNT_LAST) begin
          dm_rdata_next = '0;
          err_next      = 1'b1;
          cnt_next      = '0;
          state_next    = RESP_D;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      // Response cycle: pulse valid, no arbitration until back in IDLE.
      RESP_I:  state_next = IDLE;
      RESP_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // mem_req_o is decoded from the state so an asynchronous reset drops it
  // immediately.
  assign mem_req_o   = (state_reg == BUSY_I) || (state_reg == BUSY_D);
  assign mem_we_o    = we_reg;
  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = wdata_reg;

  assign if_valid_o  = (state_reg == RESP_I);
  assign dm_valid_o  = (state_reg == RESP_D);
  assign if_data_o   = if_data_reg;
  assign dm_rdata_o  = dm_rdata_reg;
  assign err_o       = err_reg;

  // Freeze while any asserted request has not yet received its valid pulse.
  assign stall_o = (if_req_i & ~if_valid_o) | (dm_req_i & ~dm_valid_o);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Self-checking bench for unified_mem_arbiter (TIMEOUT = 8). A behavioural
// backing memory acks after a programmable number of busy cycles. Expected
// completions are pushed to per-port queues when a request is issued. They
// are popped and compared when the matching valid pulse appears.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_valid_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_valid_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic        err_o;

  unified_mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_data_o  (if_data_o),
    .if_valid_o (if_valid_o),
    .dm_req_i   (dm_req_i),
    .dm_we_i    (dm_we_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_rdata_o (dm_rdata_o),
    .dm_valid_o (dm_valid_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .stall_o    (stall_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected completion data per port.
  logic [31:0] exp_if[$];
  logic [31:0] exp_dm[$];
  logic [31:0] last_dm;          // dm_rdata_o value the bench expects to persist
  logic [31:0] ref_store[logic [31:0]];

  // Memory model controls.
  int unsigned ack_delay = 0;
  logic        ack_never = 1'b0;
  int unsigned busy_cnt  = 0;
  logic [31:0] mem_store[logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h2010_0005;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (ref_store.exists(a)) return ref_store[a];
    return init_word(a);
  endfunction

  // Backing memory: ack on the (ack_delay+1)-th busy cycle.
  always @(negedge clk_i) begin
    if (mem_req_o) begin
      if (!ack_never && busy_cnt == ack_delay) begin
        mem_ack_i = 1'b1;
        if (mem_we_o) begin
          mem_store[mem_addr_o] = mem_wdata_o;
          mem_rdata_i = 32'hBAD0_BAD0;
        end else if (mem_store.exists(mem_addr_o)) begin
          mem_rdata_i = mem_store[mem_addr_o];
        end else begin
          mem_rdata_i = init_word(mem_addr_o);
        end
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h5555_AAAA;
      end
      busy_cnt++;
    end else begin
      mem_ack_i = 1'b0;
      busy_cnt  = 0;
    end
  end

  task automatic do_reset();
    rst_i      = 1'b1;
    if_req_i   = 1'b0;
    if_addr_i  = '0;
    dm_req_i   = 1'b0;
    dm_we_i    = 1'b0;
    dm_addr_i  = '0;
    dm_wdata_i = '0;
    ack_never  = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    exp_if.delete();
    exp_dm.delete();
    last_dm = '0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_d;
    rst_i = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    @(negedge clk_i);
    checks++;
    if ({mem_req_o, mem_we_o, if_valid_o, dm_valid_o, err_o, stall_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got req=%b we=%b ifv=%b dmv=%b err=%b stall=%b, required all 0",
               mem_req_o, mem_we_o, if_valid_o, dm_valid_o, err_o, stall_o);
    end
    checks++;
    if ({mem_addr_o, mem_wdata_o, if_data_o, dm_rdata_o} !== 128'b0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h ifd=%h dmd=%h, required 0",
               mem_addr_o, mem_wdata_o, if_data_o, dm_rdata_o);
    end
    rst_i = 1'b0;
    last_dm = '0;
    $display("reset: done");
  endtask

  // Fetch from 0x4, memory acks on the second busy cycle.
  task automatic test_fetch();
    logic [31:0] exp_d;
    int lat = 0;
    ack_delay = 1;
    @(negedge clk_i);
    if_req_i  = 1'b1;
    if_addr_i = 32'h4;
    exp_if.push_back(exp_read(32'h4));
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      if (mem_req_o) begin
        checks++;
        if (mem_addr_o !== 32'h4 || mem_we_o !== 1'b0) begin
          errors++;
          $display("FAIL fetch_mem: got addr=%h we=%b, required addr=00000004 we=0", mem_addr_o, mem_we_o);
        end
      end
      if (if_valid_o) begin lat = c; break; end
      checks++;
      if (stall_o !== 1'b1) begin
        errors++;
        $display("FAIL fetch_stall: got stall=%b at cycle %0d, required 1", stall_o, c);
      end
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL fetch_latency: got %0d cycles, required 3", lat);
    end
    if (lat != 0) begin
      exp_d = exp_if.pop_front();
      checks++;
      if (if_data_o !== exp_d || stall_o !== 1'b0) begin
        errors++;
        $display("FAIL fetch_data: got data=%h stall=%b, required data=%h stall=0", if_data_o, stall_o, exp_d);
      end
    end
    if_req_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (if_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_single_pulse: got if_valid=%b, required 0", if_valid_o);
    end
    $display("fetch: addr=00000004 data=%h latency=%0d", if_data_o, lat);
  endtask

  // Write 0xDEADBEEF to 0x20, ack on the fourth busy cycle.
  task automatic test_write();
    logic [31:0] exp_d;
    int busy = 0;
    logic got = 1'b0;
    ack_delay = 3;
    @(negedge clk_i);
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h20; dm_wdata_i = 32'hDEAD_BEEF;
    ref_store[32'h20] = 32'hDEAD_BEEF;
    exp_dm.push_back(last_dm);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      if (mem_req_o) begin
        busy++;
        checks++;
        if (mem_we_o !== 1'b1 || mem_wdata_o !== 32'hDEAD_BEEF || mem_addr_o !== 32'h20) begin
          errors++;
          $display("FAIL write_mem: got we=%b wdata=%h addr=%h, required we=1 wdata=deadbeef addr=00000020",
                   mem_we_o, mem_wdata_o, mem_addr_o);
        end
      end
      if (dm_valid_o) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || busy != 4) begin
      errors++;
      $display("FAIL write_done: got valid=%b busy_cycles=%0d, required valid=1 busy_cycles=4", got, busy);
    end
    if (got) begin
      exp_d = exp_dm.pop_front();
      checks++;
      if (dm_rdata_o !== exp_d) begin
        errors++;
        $display("FAIL write_rdata_kept: got %h, required %h", dm_rdata_o, exp_d);
      end
    end
    dm_req_i = 1'b0; dm_we_i = 1'b0;
    $display("write: addr=00000020 data=deadbeef busy_cycles=%0d", busy);
  endtask

  // Read 0x20 back while the CPU moves dm_addr_i to 0x40 mid-transaction.
  task automatic test_addr_hold();
    logic [31:0] exp_d;
    logic got = 1'b0;
    ack_delay = 3;
    @(negedge clk_i);
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h20;
    exp_dm.push_back(exp_read(32'h20));
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      if (mem_req_o) begin
        checks++;
        if (mem_addr_o !== 32'h20) begin
          errors++;
          $display("FAIL addr_hold: got mem_addr=%h at cycle %0d, required 00000020", mem_addr_o, c);
        end
      end
      if (c == 1) dm_addr_i = 32'h40;
      if (dm_valid_o) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL addr_hold_done: got no dm_valid, required a pulse");
    end else begin
      exp_d = exp_dm.pop_front();
      last_dm = exp_d;
      checks++;
      if (dm_rdata_o !== exp_d) begin
        errors++;
        $display("FAIL addr_hold_rdata: got %h, required %h", dm_rdata_o, exp_d);
      end
    end
    dm_req_i = 1'b0;
    $display("addr_hold: read 00000020 data=%h", dm_rdata_o);
  endtask

  // Read with zero-wait ack, request dropped right after grant.
  task automatic test_drop_after_grant();
    logic [31:0] exp_d;
    int lat = 0;
    ack_delay = 0;
    @(negedge clk_i);
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h30;
    exp_dm.push_back(exp_read(32'h30));
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      if (dm_valid_o) begin lat = c; break; end
      dm_req_i = 1'b0;
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL drop_latency: got %0d cycles, required 2", lat);
    end
    if (lat != 0) begin
      exp_d = exp_dm.pop_front();
      last_dm = exp_d;
      checks++;
      if (dm_rdata_o !== exp_d || stall_o !== 1'b0) begin
        errors++;
        $display("FAIL drop_data: got data=%h stall=%b, required data=%h stall=0", dm_rdata_o, stall_o, exp_d);
      end
    end
    $display("drop_after_grant: addr=00000030 data=%h latency=%0d", dm_rdata_o, lat);
  endtask

  // Both ports request continuously after reset: grants must go I,D,I,D.
  task automatic test_round_robin();
    logic [31:0] exp_d;
    logic [3:0] seq = '0;
    int ng = 0, n_if = 0, n_dm = 0;
    logic prev_req = 1'b0;
    do_reset();
    ack_delay = 1;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
    exp_if.push_back(exp_read(32'h100));
    exp_dm.push_back(exp_read(32'h200));
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_i);
      if (mem_req_o && !prev_req) begin
        if (ng < 4) seq[ng] = (mem_addr_o >= 32'h200);
        ng++;
      end
      prev_req = mem_req_o;
      if (if_valid_o) begin
        exp_d = exp_if.pop_front();
        checks++;
        if (if_data_o !== exp_d) begin
          errors++;
          $display("FAIL rr_fetch_data: got %h, required %h", if_data_o, exp_d);
        end
        $display("round_robin: fetch %0d data=%h", n_if, if_data_o);
        n_if++;
        if (n_if < 2) begin
          if_addr_i = 32'h104;
          exp_if.push_back(exp_read(32'h104));
        end else begin
          if_req_i = 1'b0;
        end
      end
      if (dm_valid_o) begin
        exp_d = exp_dm.pop_front();
        checks++;
        if (dm_rdata_o !== exp_d) begin
          errors++;
          $display("FAIL rr_data_rdata: got %h, required %h", dm_rdata_o, exp_d);
        end
        $display("round_robin: data %0d rdata=%h", n_dm, dm_rdata_o);
        last_dm = dm_rdata_o;
        n_dm++;
        if (n_dm < 2) begin
          dm_addr_i = 32'h204;
          exp_dm.push_back(exp_read(32'h204));
        end else begin
          dm_req_i = 1'b0;
        end
      end
      if (n_if == 2 && n_dm == 2) break;
    end
    checks++;
    if (n_if != 2 || n_dm != 2 || ng != 4 || seq !== 4'b1010) begin
      errors++;
      $display("FAIL rr_order: got fetches=%0d data=%0d grants=%0d seq=%b, required 2 2 4 seq=1010 (bit0 first, 1=data)",
               n_if, n_dm, ng, seq);
    end
    if_req_i = 1'b0; dm_req_i = 1'b0;
  endtask

  // Data read that the memory never acks: abandoned after 8 busy cycles.
  task automatic test_timeout();
    logic [31:0] exp_d;
    int busy = 0;
    logic got = 1'b0;
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_pre: got err=%b, required 0", err_o);
    end
    ack_never = 1'b1;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h50;
    exp_dm.push_back(32'h0);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_i);
      if (mem_req_o) busy++;
      if (dm_valid_o) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || busy != 8) begin
      errors++;
      $display("FAIL timeout_busy: got valid=%b busy_cycles=%0d, required valid=1 busy_cycles=8", got, busy);
    end
    if (got) begin
      exp_d = exp_dm.pop_front();
      checks++;
      if (dm_rdata_o !== exp_d || err_o !== 1'b1 || mem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL timeout_result: got rdata=%h err=%b req=%b, required rdata=%h err=1 req=0",
                 dm_rdata_o, err_o, mem_req_o, exp_d);
      end
    end
    last_dm = '0;
    dm_req_i = 1'b0;
    ack_never = 1'b0;
    $display("timeout: addr=00000050 busy_cycles=%0d err=%b", busy, err_o);
    // A later, normal fetch must leave the error flag set.
    ack_delay = 0;
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h8;
    exp_if.push_back(exp_read(32'h8));
    got = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      if (if_valid_o) begin got = 1'b1; break; end
    end
    if_req_i = 1'b0;
    exp_d = got ? exp_if.pop_front() : 32'h0;
    checks++;
    if (!got || if_data_o !== exp_d || err_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got valid=%b data=%h err=%b, required valid=1 data=%h err=1",
               got, if_data_o, err_o, exp_d);
    end
  endtask

  // Asynchronous reset in the middle of a data transaction.
  task automatic test_async_reset();
    logic [31:0] exp_d;
    int pulses = 0;
    int lat = 0;
    ack_delay = 5;
    @(negedge clk_i);
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h60;
    exp_dm.push_back(exp_read(32'h60));
    repeat (2) @(negedge clk_i);
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: got mem_req=%b, required 1", mem_req_o);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || err_o !== 1'b0 || dm_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got req=%b err=%b dmv=%b, required all 0", mem_req_o, err_o, dm_valid_o);
    end
    dm_req_i = 1'b0;
    exp_dm.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (dm_valid_o || mem_req_o) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL async_quiet: got %0d cycles with valid/req, required 0", pulses);
    end
    ack_delay = 0;
    if_req_i = 1'b1; if_addr_i = 32'h10;
    exp_if.push_back(exp_read(32'h10));
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      if (if_valid_o) begin lat = c; break; end
    end
    if_req_i = 1'b0;
    exp_d = (lat != 0) ? exp_if.pop_front() : 32'h0;
    checks++;
    if (lat != 2 || if_data_o !== exp_d) begin
      errors++;
      $display("FAIL async_after: got latency=%0d data=%h, required latency=2 data=%h", lat, if_data_o, exp_d);
    end
    $display("async_reset: follow-up fetch data=%h latency=%0d", if_data_o, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_addr_hold();
    test_drop_after_grant();
    test_round_robin();
    test_timeout();
    test_async_reset();
    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
